// File: rtl/rv32i_instr_encoder.sv
`default_nettype none
// ============================================================================
// Module   : rv32i_instr_encoder
// Purpose  : Packs decoded RV32I instruction fields into 32-bit machine words
//            and streams them into instruction memory at consecutive word
//            addresses. Used by the boot/test loader before core release.
//            Two-stage pipeline: encode register (s1) and memory write port.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   CLK        in   clock, rising edge
//   RESET      in   synchronous active-low reset
//   Start      in   pulse: latches BaseAddr/Len and starts a load
//   BaseAddr   in   first byte address (bits[1:0] ignored)
//   Len        in   number of instructions to load (0 -> straight to DONE)
//   InValid    in   field bundle valid
//   InReady    out  bundle accepted this cycle when InValid is also high
//   OpCode, Funct3, Funct7, Rd, Rs1, Rs2, Imm  in  decoded fields
//   MemWe      out  write strobe (stage register holds a word)
//   MemAddr    out  byte address of the pending write
//   MemWData   out  encoded instruction word
//   MemReady   in   memory accepts the write when MemWe && MemReady
//   Busy       out  loading
//   Done       out  load finished
//   Count      out  words written so far
//   Illegal    out  sticky: unknown opcode seen
//   ImmErr     out  sticky: immediate not representable in its format
// ============================================================================
module rv32i_instr_encoder #(
  parameter int          ADDR_W   = 10,
  parameter logic [31:0] NOP_WORD = 32'h00000013
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              Start,
  input  logic [ADDR_W-1:0] BaseAddr,
  input  logic [ADDR_W-3:0] Len,
  input  logic              InValid,
  output logic              InReady,
  input  logic [6:0]        OpCode,
  input  logic [2:0]        Funct3,
  input  logic [6:0]        Funct7,
  input  logic [4:0]        Rd,
  input  logic [4:0]        Rs1,
  input  logic [4:0]        Rs2,
  input  logic [31:0]       Imm,
  output logic              MemWe,
  output logic [ADDR_W-1:0] MemAddr,
  output logic [31:0]       MemWData,
  input  logic              MemReady,
  output logic              Busy,
  output logic              Done,
  output logic [ADDR_W-3:0] Count,
  output logic              Illegal,
  output logic              ImmErr
);

  localparam logic [6:0] OPC_R     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_JALR  = 7'b1100111;
  localparam logic [6:0] OPC_STORE = 7'b0100011;
  localparam logic [6:0] OPC_BR    = 7'b1100011;
  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;
  localparam logic [6:0] OPC_JAL   = 7'b1101111;

  localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(4);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t            state;
  logic [ADDR_W-3:0] len_q;
  logic [ADDR_W-3:0] accepted;
  logic              s1_valid;

  logic [31:0]       enc_word;
  logic              enc_illegal;
  logic              enc_imm_err;
  logic              imm_fits12;
  logic              write_fire;
  logic              accept;
  logic [ADDR_W-3:0] count_next;

  // Byte-lane bits of the base address are forced to zero on latch.
  logic unused_base_lsbs;
  assign unused_base_lsbs = ^BaseAddr[1:0];

  // A 12-bit signed immediate is representable when bits 31..11 are all
  // copies of the sign bit.
  assign imm_fits12 = (&Imm[31:11]) | ~(|Imm[31:11]);

  always_comb begin
    enc_word    = NOP_WORD;
    enc_illegal = 1'b0;
    enc_imm_err = 1'b0;
    case (OpCode)
      OPC_R: begin
        enc_word = {Funct7, Rs2, Rs1, Funct3, Rd, OpCode};
      end
      OPC_OPIMM, OPC_LOAD, OPC_JALR: begin
        enc_word = {Imm[11:0], Rs1, Funct3, Rd, OpCode};
        // Shift-immediates carry funct7 in the upper immediate bits.
        if ((OpCode == OPC_OPIMM) && ((Funct3 == 3'b001) || (Funct3 == 3'b101))) begin
          enc_word[31:20] = {Funct7, Imm[4:0]};
        end
        enc_imm_err = ~imm_fits12;
      end
      OPC_STORE: begin
        enc_word    = {Imm[11:5], Rs2, Rs1, Funct3, Imm[4:0], OpCode};
        enc_imm_err = ~imm_fits12;
      end
      OPC_BR: begin
        enc_word    = {Imm[12], Imm[10:5], Rs2, Rs1, Funct3, Imm[4:1], Imm[11], OpCode};
        enc_imm_err = Imm[0];
      end
      OPC_LUI, OPC_AUIPC: begin
        enc_word = {Imm[31:12], Rd, OpCode};
      end
      OPC_JAL: begin
        enc_word    = {Imm[20], Imm[10:1], Imm[11], Imm[19:12], Rd, OpCode};
        enc_imm_err = Imm[0];
      end
      default: begin
        enc_word    = NOP_WORD;
        enc_illegal = 1'b1;
      end
    endcase
  end

  assign write_fire = s1_valid & MemReady;
  // The stage register may be refilled on the same edge it drains.
  assign InReady    = (state == ST_LOAD) && (accepted < len_q) && (!s1_valid || MemReady);
  assign accept     = InValid & InReady;
  assign count_next = Count + 1'b1;

  assign MemWe = s1_valid;
  assign Busy  = (state == ST_LOAD);
  assign Done  = (state == ST_DONE);

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state    <= ST_IDLE;
      len_q    <= '0;
      accepted <= '0;
      s1_valid <= 1'b0;
      MemAddr  <= '0;
      MemWData <= '0;
      Count    <= '0;
      Illegal  <= 1'b0;
      ImmErr   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (Start) begin
            MemAddr  <= {BaseAddr[ADDR_W-1:2], 2'b00};
            len_q    <= Len;
            accepted <= '0;
            Count    <= '0;
            Illegal  <= 1'b0;
            ImmErr   <= 1'b0;
            state    <= (Len == '0) ? ST_DONE : ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (write_fire) begin
            Count   <= count_next;
            MemAddr <= MemAddr + ADDR_STEP;
            if (count_next == len_q) begin
              state <= ST_DONE;
            end
          end
          if (accept) begin
            s1_valid <= 1'b1;
            MemWData <= enc_word;
            accepted <= accepted + 1'b1;
            Illegal  <= Illegal | enc_illegal;
            ImmErr   <= ImmErr | enc_imm_err;
          end else if (write_fire) begin
            s1_valid <= 1'b0;
          end
        end
        ST_DONE: begin
          if (Start) begin
            state   <= ST_IDLE;
            Count   <= '0;
            Illegal <= 1'b0;
            ImmErr  <= 1'b0;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rv32i_instr_encoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_rv32i_instr_encoder
// Purpose  : Self-checking bench for rv32i_instr_encoder. A transaction-level
//            model (expected-write queue plus load bookkeeping) is compared
//            against the DUT every cycle; directed cases pin known encodings.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rv32i_instr_encoder;
  localparam int ADDR_W = 10;

  logic              CLK;
  logic              RESET;
  logic              Start;
  logic [ADDR_W-1:0] BaseAddr;
  logic [ADDR_W-3:0] Len;
  logic              InValid;
  logic              InReady;
  logic [6:0]        OpCode;
  logic [2:0]        Funct3;
  logic [6:0]        Funct7;
  logic [4:0]        Rd, Rs1, Rs2;
  logic [31:0]       Imm;
  logic              MemWe;
  logic [ADDR_W-1:0] MemAddr;
  logic [31:0]       MemWData;
  logic              MemReady;
  logic              Busy, Done;
  logic [ADDR_W-3:0] Count;
  logic              Illegal, ImmErr;

  rv32i_instr_encoder #(.ADDR_W(ADDR_W), .NOP_WORD(32'h00000013)) dut (
    .CLK(CLK), .RESET(RESET), .Start(Start), .BaseAddr(BaseAddr), .Len(Len),
    .InValid(InValid), .InReady(InReady), .OpCode(OpCode), .Funct3(Funct3),
    .Funct7(Funct7), .Rd(Rd), .Rs1(Rs1), .Rs2(Rs2), .Imm(Imm),
    .MemWe(MemWe), .MemAddr(MemAddr), .MemWData(MemWData), .MemReady(MemReady),
    .Busy(Busy), .Done(Done), .Count(Count), .Illegal(Illegal), .ImmErr(ImmErr)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm;
  } bundle_t;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
    int                cyc;
  } wr_t;

  int checks = 0;
  int errors = 0;
  int cycle  = 0;
  bit chk_en = 0;

  bundle_t bq[$];
  wr_t     wlog[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference encoding from the ISA field layout ----------
  function automatic logic [31:0] ref_word(input bundle_t b);
    logic [31:0] op, f3, f7, rd, rs1, rs2, imm, i12;
    op = 32'(b.op); f3 = 32'(b.f3); f7 = 32'(b.f7);
    rd = 32'(b.rd); rs1 = 32'(b.rs1); rs2 = 32'(b.rs2); imm = b.imm;
    case (b.op)
      7'h33: return op | (rd << 7) | (f3 << 12) | (rs1 << 15) | (rs2 << 20) | (f7 << 25);
      7'h13, 7'h03, 7'h67: begin
        i12 = imm & 32'hFFF;
        if (b.op == 7'h13 && (b.f3 == 3'd1 || b.f3 == 3'd5)) i12 = (f7 << 5) | (imm & 32'h1F);
        return op | (rd << 7) | (f3 << 12) | (rs1 << 15) | (i12 << 20);
      end
      7'h23: return op | ((imm & 32'h1F) << 7) | (f3 << 12) | (rs1 << 15) | (rs2 << 20)
                    | (((imm >> 5) & 32'h7F) << 25);
      7'h63: return op | (((imm >> 11) & 1) << 7) | (((imm >> 1) & 32'hF) << 8) | (f3 << 12)
                    | (rs1 << 15) | (rs2 << 20) | (((imm >> 5) & 32'h3F) << 25)
                    | (((imm >> 12) & 1) << 31);
      7'h37, 7'h17: return op | (rd << 7) | (imm & 32'hFFFFF000);
      7'h6F: return op | (rd << 7) | (((imm >> 12) & 32'hFF) << 12) | (((imm >> 11) & 1) << 20)
                    | (((imm >> 1) & 32'h3FF) << 21) | (((imm >> 20) & 1) << 31);
      default: return 32'h00000013;
    endcase
  endfunction

  function automatic bit ref_illegal(input bundle_t b);
    return !(b.op inside {7'h33, 7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F});
  endfunction

  function automatic bit ref_immerr(input bundle_t b);
    if (b.op inside {7'h13, 7'h03, 7'h67, 7'h23})
      return ($signed(b.imm) < -2048) || ($signed(b.imm) > 2047);
    if (b.op inside {7'h63, 7'h6F}) return b.imm[0];
    return 1'b0;
  endfunction

  function automatic bundle_t mk(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                                 input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                                 input logic [31:0] imm);
    bundle_t b;
    b.op = op; b.f3 = f3; b.f7 = f7; b.rd = rd; b.rs1 = rs1; b.rs2 = rs2; b.imm = imm;
    return b;
  endfunction

  // ---------------- transaction-level model --------------------------------
  int                m_state;   // 0 idle, 1 loading, 2 done
  int                m_len, m_acc, m_cnt;
  logic [ADDR_W-1:0] m_addr;
  logic [31:0]       m_pend[$];
  bit                m_ill, m_ie;
  bit                m_wr, m_take;
  bundle_t           m_b;

  always @(posedge CLK) begin
    cycle++;
    if (!RESET) begin
      m_state = 0; m_len = 0; m_acc = 0; m_cnt = 0; m_addr = '0;
      m_pend.delete(); m_ill = 0; m_ie = 0;
    end else begin
      case (m_state)
        0: if (Start) begin
          m_addr = BaseAddr & 10'h3FC;
          m_len = int'(Len); m_acc = 0; m_cnt = 0; m_ill = 0; m_ie = 0;
          m_state = (Len == 0) ? 2 : 1;
        end
        1: begin
          m_wr   = (m_pend.size() > 0) && MemReady;
          m_take = InValid && (m_acc < m_len) && ((m_pend.size() == 0) || MemReady);
          if (m_wr) begin
            void'(m_pend.pop_front());
            m_cnt++;
            m_addr = m_addr + 10'd4;
            if (m_cnt == m_len) m_state = 2;
          end
          if (m_take) begin
            m_b = mk(OpCode, Funct3, Funct7, Rd, Rs1, Rs2, Imm);
            m_pend.push_back(ref_word(m_b));
            m_acc++;
            m_ill = m_ill | ref_illegal(m_b);
            m_ie  = m_ie | ref_immerr(m_b);
          end
        end
        default: if (Start) begin
          m_state = 0; m_cnt = 0; m_ill = 0; m_ie = 0;
        end
      endcase
    end
  end

  // ---------------- single compare process ---------------------------------
  always @(negedge CLK) begin
    if (chk_en) begin
      chk("in_ready", 32'(InReady),
          32'((m_state == 1) && (m_acc < m_len) && ((m_pend.size() == 0) || MemReady)));
      chk("mem_we", 32'(MemWe), 32'(m_pend.size() != 0));
      chk("mem_addr", 32'(MemAddr), 32'(m_addr));
      if (m_pend.size() != 0) chk("mem_wdata", MemWData, m_pend[0]);
      chk("busy", 32'(Busy), 32'(m_state == 1));
      chk("done", 32'(Done), 32'(m_state == 2));
      chk("count", 32'(Count), 32'(m_cnt));
      chk("illegal", 32'(Illegal), 32'(m_ill));
      chk("imm_err", 32'(ImmErr), 32'(m_ie));
      if (MemWe && MemReady) wlog.push_back('{addr: MemAddr, data: MemWData, cyc: cycle});
    end
  end

  // ---------------- stimulus helpers ---------------------------------------
  task automatic step();
    @(posedge CLK); #1;
  endtask

  task automatic start_load(input logic [ADDR_W-1:0] base, input int len);
    if (Done === 1'b1) begin
      Start = 1'b1; step(); Start = 1'b0;
    end
    wlog.delete();
    Start = 1'b1; BaseAddr = base; Len = (ADDR_W-2)'(len);
    step();
    Start = 1'b0;
  endtask

  // Drives queued bundles until the load completes (or Count reaches stop_cnt).
  task automatic feed(input int rdy_pct, input int vld_pct, input int stall_idx,
                      input int stall_n, input int stop_cnt, input bit start_noise);
    int  budget = 0;
    int  stalled = 0;
    bit  took;
    forever begin
      if (Done === 1'b1) break;
      if (stop_cnt > 0 && int'(Count) >= stop_cnt) break;
      if (budget++ > 3000) begin
        chk("feed_timeout", 32'(Done), 32'd1);
        break;
      end
      if (MemWe && int'(Count) == stall_idx && stalled < stall_n) begin
        MemReady = 1'b0; stalled++;
      end else begin
        MemReady = ($urandom_range(99) < rdy_pct);
      end
      Start = start_noise && Busy && ($urandom_range(99) < 5);
      if (bq.size() > 0 && $urandom_range(99) < vld_pct) begin
        InValid = 1'b1;
        OpCode = bq[0].op; Funct3 = bq[0].f3; Funct7 = bq[0].f7;
        Rd = bq[0].rd; Rs1 = bq[0].rs1; Rs2 = bq[0].rs2; Imm = bq[0].imm;
      end else begin
        InValid = 1'b0;
        Imm = $urandom();
      end
      #3;
      took = InValid && InReady;
      step();
      if (took) void'(bq.pop_front());
    end
    InValid = 1'b0; Start = 1'b0; MemReady = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ------------------------------------------
  initial begin
    logic [6:0] legal_ops [9];
    legal_ops = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F};
    RESET = 1'b0; Start = 1'b0; BaseAddr = '0; Len = '0; InValid = 1'b0; MemReady = 1'b1;
    OpCode = '0; Funct3 = '0; Funct7 = '0; Rd = '0; Rs1 = '0; Rs2 = '0; Imm = '0;
    step(); step();
    chk_en = 1'b1;
    chk("rst_mem_we", 32'(MemWe), 32'd0);
    chk("rst_mem_addr", 32'(MemAddr), 32'd0);
    chk("rst_mem_wdata", MemWData, 32'd0);
    chk("rst_done_busy", {30'd0, Done, Busy}, 32'd0);
    RESET = 1'b1;
    step();

    // model pins (hand-computed encodings)
    chk("pin_sub", ref_word(mk(7'h33, 3'd0, 7'h20, 5'd3, 5'd1, 5'd2, 32'd0)), 32'h402081B3);
    chk("pin_slli", ref_word(mk(7'h13, 3'd1, 7'h00, 5'd1, 5'd1, 5'd0, 32'd3)), 32'h00309093);
    chk("pin_jal_neg", ref_word(mk(7'h6F, 3'd0, 7'h0, 5'd0, 5'd0, 5'd0, 32'hFFFFFFFC)), 32'hFFDFF06F);

    // single addi
    start_load(10'h100, 1);
    bq.push_back(mk(7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5));
    feed(100, 100, -1, 0, 0, 0);
    chk("t1_nwr", 32'(wlog.size()), 32'd1);
    if (wlog.size() >= 1) begin
      chk("t1_addr", 32'(wlog[0].addr), 32'h100);
      chk("t1_data", wlog[0].data, 32'h00500093);
    end
    chk("t1_done", 32'(Done), 32'd1);
    chk("t1_count", 32'(Count), 32'd1);

    // back-to-back add / sub / lui
    start_load(10'h100, 3);
    bq.push_back(mk(7'h33, 3'd0, 7'h00, 5'd3, 5'd1, 5'd2, 32'd0));
    bq.push_back(mk(7'h33, 3'd0, 7'h20, 5'd3, 5'd1, 5'd2, 32'd0));
    bq.push_back(mk(7'h37, 3'd0, 7'h00, 5'd5, 5'd0, 5'd0, 32'h12345000));
    feed(100, 100, -1, 0, 0, 0);
    chk("t2_nwr", 32'(wlog.size()), 32'd3);
    if (wlog.size() >= 3) begin
      chk("t2_d0", wlog[0].data, 32'h002081B3);
      chk("t2_d1", wlog[1].data, 32'h402081B3);
      chk("t2_d2", wlog[2].data, 32'h123452B7);
      chk("t2_a2", 32'(wlog[2].addr), 32'h108);
      chk("t2_b2b", 32'(wlog[2].cyc - wlog[0].cyc), 32'd2);
    end

    // store / branch / jal with a 3-cycle stall on the second word
    start_load(10'h100, 3);
    bq.push_back(mk(7'h23, 3'd2, 7'h00, 5'd0, 5'd1, 5'd2, 32'd8));
    bq.push_back(mk(7'h63, 3'd0, 7'h00, 5'd0, 5'd1, 5'd2, 32'd8));
    bq.push_back(mk(7'h6F, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'd16));
    feed(100, 100, 1, 3, 0, 0);
    chk("t3_nwr", 32'(wlog.size()), 32'd3);
    if (wlog.size() >= 3) begin
      chk("t3_d0", wlog[0].data, 32'h0020A423);
      chk("t3_d1", wlog[1].data, 32'h00208463);
      chk("t3_d2", wlog[2].data, 32'h010000EF);
      chk("t3_stall", 32'(wlog[1].cyc - wlog[0].cyc), 32'd4);
    end

    // illegal opcode, then misaligned branch offset
    start_load(10'h100, 2);
    bq.push_back(mk(7'h7F, 3'd0, 7'h00, 5'd1, 5'd1, 5'd2, 32'd0));
    bq.push_back(mk(7'h63, 3'd0, 7'h00, 5'd0, 5'd1, 5'd2, 32'd7));
    feed(100, 100, -1, 0, 0, 0);
    if (wlog.size() >= 2) begin
      chk("t4_d0", wlog[0].data, 32'h00000013);
      chk("t4_d1", wlog[1].data, 32'h00208363);
    end
    chk("t4_flags", {30'd0, Illegal, ImmErr}, 32'd3);
    chk("t4_count", 32'(Count), 32'd2);

    // address wrap
    start_load(10'h3FC, 2);
    bq.push_back(mk(7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd1));
    bq.push_back(mk(7'h13, 3'd0, 7'd0, 5'd2, 5'd0, 5'd0, 32'd2));
    feed(100, 100, -1, 0, 0, 0);
    if (wlog.size() >= 2) begin
      chk("t5_a0", 32'(wlog[0].addr), 32'h3FC);
      chk("t5_a1", 32'(wlog[1].addr), 32'h000);
    end

    // reset in the middle of a load, then an empty load
    start_load(10'h040, 4);
    for (int i = 0; i < 4; i++) bq.push_back(mk(7'h13, 3'd0, 7'd0, 5'(i), 5'd0, 5'd0, 32'(i)));
    feed(100, 100, -1, 0, 1, 0);
    bq.delete();
    RESET = 1'b0;
    step();
    chk("t6_rst_out", {25'd0, InReady, MemWe, Busy, Done, Illegal, ImmErr, 1'b0}, 32'd0);
    chk("t6_rst_cnt", 32'(Count), 32'd0);
    chk("t6_rst_data", MemWData, 32'd0);
    RESET = 1'b1;
    step();
    start_load(10'h080, 0);
    chk("t6_len0_done", 32'(Done), 32'd1);
    chk("t6_len0_we", 32'(MemWe), 32'd0);

    // randomized loads
    for (int n = 0; n < 25; n++) begin
      int len;
      len = $urandom_range(1, 8);
      start_load(ADDR_W'($urandom()), len);
      for (int k = 0; k < len; k++) begin
        bundle_t b;
        b.op  = ($urandom_range(9) == 0) ? 7'($urandom()) : legal_ops[$urandom_range(8)];
        b.f3  = 3'($urandom()); b.f7 = 7'($urandom());
        b.rd  = 5'($urandom()); b.rs1 = 5'($urandom()); b.rs2 = 5'($urandom());
        b.imm = ($urandom_range(1) == 0) ? 32'($signed($urandom_range(0, 8191)) - 4096)
                                         : 32'($urandom());
        bq.push_back(b);
      end
      feed(70, 70, -1, 0, 0, 1);
      chk("rnd_nwr", 32'(wlog.size()), 32'(len));
      bq.delete();
    end

    step(); step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
